// File: rtl/cpu_pkg.sv
// Shared types for the bit-serial CPU front end.
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 4;

  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    FULL    = 2'd2,
    EXEC    = 2'd3
  } load_state_t;

endpackage

// File: rtl/instr_loader_btn_conditioner.sv
// Push-button conditioning: 2-flop sync, optional debounce, rising-edge pulse.
// Debounce filter is built only when DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic btn_edge
);

  logic s1;
  logic s2;
  logic lvl;
  logic lvl_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      lvl_q    <= 1'b0;
      btn_edge <= 1'b0;
    end else begin
      s1       <= btn_raw;
      s2       <= s1;
      lvl_q    <= lvl;
      btn_edge <= lvl & ~lvl_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;

  // lvl follows s2 only after it has disagreed for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (s2 == lvl) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
      lvl <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lvl <= 1'b0;
    else       lvl <= s2;
  end
`endif

endmodule

// File: rtl/instr_loader.sv
// Two-byte instruction loader with button handshake to the control FSM.
// Define DEBOUNCE_EN to insert the button debounce filter.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          btn_raw,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          clr,
  input  logic                          inst_ack,
  output logic [OPCODE_W-1:0]           opcode,
  output logic [INSTR_W-OPCODE_W-1:0]   instr,
  output logic                          inst_done,
  output logic                          btn_edge,
  output logic [1:0]                    load_state
);

  load_state_t        state;
  load_state_t        state_nx;
  logic [INSTR_W-1:0] instr_reg;
  logic [INSTR_W-1:0] instr_nx;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rstn    (rstn),
    .btn_raw (btn_raw),
    .btn_edge(btn_edge)
  );

  // clr beats inst_ack beats the button
  always_comb begin
    state_nx = state;
    instr_nx = instr_reg;
    if (clr) begin
      state_nx = LOAD_LO;
      instr_nx = '0;
    end else if (inst_ack && state == EXEC) begin
      state_nx = LOAD_LO;
    end else if (btn_edge) begin
      unique case (state)
        LOAD_LO: begin
          instr_nx[DATA_W-1:0] = data_in;
          state_nx = LOAD_HI;
        end
        LOAD_HI: begin
          instr_nx[INSTR_W-1:DATA_W] = data_in;
          state_nx = FULL;
        end
        FULL:    state_nx = EXEC;
        EXEC:    state_nx = EXEC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= LOAD_LO;
      instr_reg <= '0;
      inst_done <= 1'b0;
    end else begin
      state     <= state_nx;
      instr_reg <= instr_nx;
      inst_done <= (state_nx == FULL) || (state_nx == EXEC);
    end
  end

  assign opcode     = instr_reg[OPCODE_W-1:0];
  assign instr      = instr_reg[INSTR_W-1:OPCODE_W];
  assign load_state = state;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: vector table plus multi-cycle sequences.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        btn_raw;
  logic [7:0]  data_in;
  logic        clr;
  logic        inst_ack;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        btn_edge;
  logic [1:0]  load_state;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  logic       done_at_edge;
  logic [1:0] state_at_edge;

`ifdef DEBOUNCE_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 4;
`endif

  instr_loader dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_raw   (btn_raw),
    .data_in   (data_in),
    .clr       (clr),
    .inst_ack  (inst_ack),
    .opcode    (opcode),
    .instr     (instr),
    .inst_done (inst_done),
    .btn_edge  (btn_edge),
    .load_state(load_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (btn_edge) pulses++;

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // mode: 0 plain, 1 clr with the pulse, 2 inst_ack with the pulse
  task automatic press(input logic [7:0] d, input int mode);
    logic seen;
    seen = 1'b0;
    data_in = d;
    btn_raw = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (btn_edge) seen = 1'b1;
    end
    chk("edge_seen", {15'd0, seen}, 16'd1);
    done_at_edge  = inst_done;
    state_at_edge = load_state;
    if (mode == 1) clr = 1'b1;
    if (mode == 2) inst_ack = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    inst_ack = 1'b0;
    btn_raw = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic pulse_in(input int which);
    @(negedge clk);
    if (which == 3) inst_ack = 1'b1;
    else            clr = 1'b1;
    @(negedge clk);
    inst_ack = 1'b0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st,
                         input logic [15:0] ir, input logic dn);
    chk({tag, "_state"}, {14'd0, load_state}, {14'd0, st});
    chk({tag, "_opcode"}, {12'd0, opcode}, {12'd0, ir[3:0]});
    chk({tag, "_instr"}, {4'd0, instr}, {4'd0, ir[15:4]});
    chk({tag, "_done"}, {15'd0, inst_done}, {15'd0, dn});
  endtask

  typedef struct {
    int         op;
    logic [7:0] d;
    logic [1:0] st;
    logic [15:0] ir;
    logic       dn;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int first;
    // op: 0 press, 1 press+clr, 2 press+ack, 3 ack, 4 clr
    vecs[0]  = '{0, 8'h34, 2'd1, 16'h0034, 1'b0};
    vecs[1]  = '{0, 8'h12, 2'd2, 16'h1234, 1'b1};
    vecs[2]  = '{0, 8'h99, 2'd3, 16'h1234, 1'b1};
    vecs[3]  = '{0, 8'h55, 2'd3, 16'h1234, 1'b1};
    vecs[4]  = '{3, 8'h00, 2'd0, 16'h1234, 1'b0};
    vecs[5]  = '{3, 8'h00, 2'd0, 16'h1234, 1'b0};
    vecs[6]  = '{0, 8'hAB, 2'd1, 16'h12AB, 1'b0};
    vecs[7]  = '{1, 8'hCD, 2'd0, 16'h0000, 1'b0};
    vecs[8]  = '{0, 8'h0F, 2'd1, 16'h000F, 1'b0};
    vecs[9]  = '{0, 8'hF0, 2'd2, 16'hF00F, 1'b1};
    vecs[10] = '{0, 8'h77, 2'd3, 16'hF00F, 1'b1};
    vecs[11] = '{2, 8'h66, 2'd0, 16'hF00F, 1'b0};
    vecs[12] = '{0, 8'h5A, 2'd1, 16'hF05A, 1'b0};
    vecs[13] = '{4, 8'h00, 2'd0, 16'h0000, 1'b0};

    rstn = 1'b0;
    btn_raw = 1'b0;
    data_in = 8'h00;
    clr = 1'b0;
    inst_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset", 2'd0, 16'h0000, 1'b0);
    chk("reset_edge", {15'd0, btn_edge}, 16'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      pulses = 0;
      if (vecs[i].op <= 2) press(vecs[i].d, vecs[i].op);
      else                 pulse_in(vecs[i].op);
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].ir, vecs[i].dn);
      chk($sformatf("vec%0d_pulses", i), 16'(pulses),
          (vecs[i].op <= 2) ? 16'd1 : 16'd0);
    end

    // latency and held button: one pulse only
    pulses = 0;
    first = 0;
    data_in = 8'h34;
    btn_raw = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (btn_edge && first == 0) first = k;
    end
    chk("latency", 16'(first), 16'(LAT));
    chk("held_pulses", 16'(pulses), 16'd1);
    btn_raw = 1'b0;
    repeat (25) @(negedge clk);
    chk_out("held", 2'd1, 16'h0034, 1'b0);

    // second press cannot start the FSM; third press does
    press(8'h12, 0);
    chk("press2_done_at_edge", {15'd0, done_at_edge}, 16'd0);
    chk_out("full", 2'd2, 16'h1234, 1'b1);
    press(8'h99, 0);
    chk("press3_done_at_edge", {15'd0, done_at_edge}, 16'd1);
    chk("press3_state_at_edge", {14'd0, state_at_edge}, 16'd2);
    press(8'hEE, 0);
    press(8'hDD, 0);
    chk_out("exec", 2'd3, 16'h1234, 1'b1);
    pulse_in(3);
    chk_out("acked", 2'd0, 16'h1234, 1'b0);

    // asynchronous reset in LOAD_HI with a press in flight
    press(8'hAB, 0);
    btn_raw = 1'b1;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk_out("async_rst", 2'd0, 16'h0000, 1'b0);
    chk("async_rst_edge", {15'd0, btn_edge}, 16'd0);
    btn_raw = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    repeat (30) @(negedge clk);
    chk("post_rst_pulses", 16'(pulses), 16'd0);
    chk_out("post_rst", 2'd0, 16'h0000, 1'b0);

`ifdef DEBOUNCE_EN
    pulses = 0;
    btn_raw = 1'b1;
    repeat (10) @(negedge clk);
    btn_raw = 1'b0;
    repeat (40) @(negedge clk);
    chk("glitch_pulses", 16'(pulses), 16'd0);
    first = 0;
    btn_raw = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 20) btn_raw = 1'b0;
      if (btn_edge && first == 0) first = k;
    end
    chk("debounce_latency", 16'(first), 16'd20);
    chk("debounce_pulses", 16'(pulses), 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
